// File: rtl/contador_secuenciador.sv
// Job sequencer for the N-bit counter datapath: preload, confirm the load on Q,
// then count for a programmed number of enabled cycles while tallying RCO events.
module contador_secuenciador #(
  parameter int N     = 4,
  parameter int STEPW = 8,
  parameter int TMO   = 4
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             iStart,
  input  logic             iAbort,
  input  logic [1:0]       iModo,
  input  logic [N-1:0]     iCarga,
  input  logic [STEPW-1:0] iPasos,
  input  logic [N-1:0]     iQ,
  input  logic             iRCO,
  output logic [1:0]       oModo,
  output logic             oENB,
  output logic [N-1:0]     oD,
  output logic             oBusy,
  output logic             oDone,
  output logic             oErr,
  output logic [STEPW-1:0] oNumRCO
);

  localparam int TW = $clog2(TMO + 1);
  localparam logic [STEPW-1:0] ONE = 1;
  localparam logic [TW-1:0]    TMO_LAST = TW'(TMO - 1);
  localparam logic [1:0]       M_LOAD = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CHECK, S_RUN, S_DONE, S_ERR} state_t;

  state_t           state_q;
  logic [1:0]       modo_cap_q;
  logic [N-1:0]     carga_q;
  logic [STEPW-1:0] pasos_q;
  logic [STEPW-1:0] step_q;
  logic [TW-1:0]    tmo_q;
  logic [1:0]       modo_q;
  logic             enb_q;
  logic [N-1:0]     d_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;
  logic [STEPW-1:0] nrco_q;

  // The counter registers RCO with Q, so the carry of the last RUN step shows up in DONE.
  logic rco_win;
  assign rco_win = (state_q == S_RUN) || (state_q == S_DONE);

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      modo_cap_q <= '0;
      carga_q    <= '0;
      pasos_q    <= '0;
      step_q     <= '0;
      tmo_q      <= '0;
      modo_q     <= '0;
      enb_q      <= 1'b0;
      d_q        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      nrco_q     <= '0;
    end else begin
      done_q <= 1'b0;
      if (iAbort) begin
        state_q <= S_IDLE;
        modo_q  <= '0;
        enb_q   <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        if (rco_win && iRCO && (nrco_q != '1)) nrco_q <= nrco_q + ONE;
        case (state_q)
          S_IDLE: begin
            if (iStart) begin
              modo_cap_q <= iModo;
              carga_q    <= iCarga;
              pasos_q    <= iPasos;
              err_q      <= 1'b0;
              nrco_q     <= '0;
              d_q        <= iCarga;
              modo_q     <= M_LOAD;
              enb_q      <= 1'b1;
              busy_q     <= 1'b1;
              state_q    <= S_LOAD;
            end
          end
          S_LOAD: begin
            enb_q   <= 1'b0;
            tmo_q   <= '0;
            state_q <= S_CHECK;
          end
          S_CHECK: begin
            if (iQ == carga_q) begin
              if (modo_cap_q == M_LOAD || pasos_q == '0) begin
                modo_q  <= '0;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= S_DONE;
              end else begin
                step_q  <= pasos_q;
                modo_q  <= modo_cap_q;
                enb_q   <= 1'b1;
                state_q <= S_RUN;
              end
            end else if (tmo_q == TMO_LAST) begin
              modo_q  <= '0;
              busy_q  <= 1'b0;
              err_q   <= 1'b1;
              state_q <= S_ERR;
            end else begin
              tmo_q <= tmo_q + 1'b1;
            end
          end
          S_RUN: begin
            step_q <= step_q - ONE;
            if (step_q == ONE) begin
              modo_q  <= '0;
              enb_q   <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end
          S_DONE:  state_q <= S_IDLE;
          S_ERR:   state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign oModo   = modo_q;
  assign oENB    = enb_q;
  assign oD      = d_q;
  assign oBusy   = busy_q;
  assign oDone   = done_q;
  assign oErr    = err_q;
  assign oNumRCO = nrco_q;

endmodule

// File: tb/tb_contador_secuenciador.sv
// Bench for contador_secuenciador: a counter model closes the loop on iQ/iRCO and a
// per-job expected output trace is checked on every falling edge.
module tb_contador_secuenciador;

  logic       CLK = 1'b0;
  logic       Reset = 1'b1;
  logic       iStart = 1'b0, iAbort = 1'b0;
  logic [1:0] iModo = '0;
  logic [3:0] iCarga = '0;
  logic [7:0] iPasos = '0;
  logic [3:0] iQ;
  logic       iRCO;
  logic [1:0] oModo;
  logic       oENB, oBusy, oDone, oErr;
  logic [3:0] oD;
  logic [7:0] oNumRCO;

  contador_secuenciador #(.N(4), .STEPW(8), .TMO(4)) dut (
    .CLK(CLK), .Reset(Reset), .iStart(iStart), .iAbort(iAbort), .iModo(iModo),
    .iCarga(iCarga), .iPasos(iPasos), .iQ(iQ), .iRCO(iRCO), .oModo(oModo), .oENB(oENB),
    .oD(oD), .oBusy(oBusy), .oDone(oDone), .oErr(oErr), .oNumRCO(oNumRCO)
  );

  always #5 CLK = ~CLK;

  // Counter datapath: registered Q and carry/borrow flag.
  logic [3:0] cnt_q;
  logic       rco_q;
  bit         stuck = 1'b0;
  assign iQ   = stuck ? 4'h0 : cnt_q;
  assign iRCO = rco_q;

  always @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      cnt_q <= '0; rco_q <= 1'b0;
    end else if (oENB) begin
      case (oModo)
        2'b00: begin cnt_q <= cnt_q + 4'd1; rco_q <= (cnt_q == 4'hF); end
        2'b01: begin cnt_q <= cnt_q - 4'd1; rco_q <= (cnt_q == 4'h0); end
        2'b10: begin cnt_q <= cnt_q - 4'd3; rco_q <= (cnt_q < 4'd3); end
        default: begin cnt_q <= oD; rco_q <= 1'b0; end
      endcase
    end else begin
      rco_q <= 1'b0;
    end
  end

  typedef struct packed {
    logic [1:0] modo; logic enb; logic [3:0] d; logic busy; logic done; logic err; logic [7:0] nrco;
  } exp_t;

  exp_t q[$];
  logic [3:0] m_d = '0;
  logic       m_err = 1'b0;
  logic [7:0] m_nrco = '0;
  bit         chk_en = 1'b0;
  int         n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin : cmp
    exp_t e;
    if (chk_en) begin
      if (q.size() > 0) e = q.pop_front();
      else e = '{modo: 2'b00, enb: 1'b0, d: m_d, busy: 1'b0, done: 1'b0, err: m_err, nrco: m_nrco};
      chk("oModo", int'(oModo), int'(e.modo));
      chk("oENB", int'(oENB), int'(e.enb));
      chk("oD", int'(oD), int'(e.d));
      chk("oBusy", int'(oBusy), int'(e.busy));
      chk("oDone", int'(oDone), int'(e.done));
      chk("oErr", int'(oErr), int'(e.err));
      chk("oNumRCO", int'(oNumRCO), int'(e.nrco));
    end
  end

  function automatic logic [7:0] sat(input int v);
    return (v > 255) ? 8'hFF : 8'(v);
  endfunction

  // Expected outputs from the LOAD cycle onward, plus the idle values left behind.
  task automatic build(input logic [1:0] m, input logic [3:0] c, input int p,
                       input bit stk, input int abort_at);
    exp_t e;
    int cum[$];
    int v;
    e = '{modo: 2'b11, enb: 1'b1, d: c, busy: 1'b1, done: 1'b0, err: 1'b0, nrco: 8'h00};
    q.push_back(e);
    e.enb = 1'b0;
    m_d = c; m_err = 1'b0; m_nrco = '0;
    if (stk && c != 4'h0) begin
      repeat (4) q.push_back(e);
      e.modo = 2'b00; e.busy = 1'b0; e.err = 1'b1;
      q.push_back(e);
      m_err = 1'b1;
      return;
    end
    q.push_back(e);
    if (m == 2'b11 || p == 0) begin
      e.modo = 2'b00; e.busy = 1'b0; e.done = 1'b1;
      q.push_back(e);
      return;
    end
    v = int'(c);
    cum.push_back(0);
    for (int k = 1; k <= p; k++) begin
      int w;
      case (m)
        2'b00: begin w = (v == 15) ? 1 : 0; v = (v + 1) % 16; end
        2'b01: begin w = (v == 0) ? 1 : 0; v = (v + 15) % 16; end
        default: begin w = (v < 3) ? 1 : 0; v = (v + 13) % 16; end
      endcase
      cum.push_back(cum[k-1] + w);
    end
    for (int k = 1; k <= p; k++) begin
      e.modo = m; e.enb = 1'b1;
      e.nrco = (k >= 2) ? sat(cum[k-2]) : 8'h00;
      q.push_back(e);
      if (k == abort_at) begin
        m_nrco = e.nrco;
        return;
      end
    end
    e.modo = 2'b00; e.enb = 1'b0; e.busy = 1'b0; e.done = 1'b1; e.nrco = sat(cum[p-1]);
    q.push_back(e);
    m_nrco = sat(cum[p]);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && q.size() > 0; i++) begin
      @(negedge CLK); #1;
    end
    if (q.size() > 0) begin
      n_chk++; n_fail++;
      $display("FAIL drain: %0d expected cycles left, expected 0", q.size());
      q.delete();
    end
    @(posedge CLK); #1;
  endtask

  task automatic job(input logic [1:0] m, input logic [3:0] c, input logic [7:0] p,
                     input bit stk, input int abort_at, input bit busy_start);
    @(posedge CLK); #1;
    iStart = 1'b1; iModo = m; iCarga = c; iPasos = p; stuck = stk;
    @(posedge CLK); #1;
    iStart = 1'b0;
    build(m, c, int'(p), stk, abort_at);
    if (abort_at > 0) begin
      for (int cyc = 1; cyc <= abort_at + 1; cyc++) begin
        @(posedge CLK); #1;
        iStart = busy_start && (cyc == 2);
        iModo = 2'b00; iCarga = 4'h0; iPasos = 8'd1;
        iAbort = (cyc == abort_at + 1);
      end
      @(posedge CLK); #1;
      iAbort = 1'b0; iStart = 1'b0;
    end
    drain();
    stuck = 1'b0;
  endtask

  task automatic chk_reset_outs();
    chk("rst_oModo", int'(oModo), 0);
    chk("rst_oENB", int'(oENB), 0);
    chk("rst_oD", int'(oD), 0);
    chk("rst_oBusy", int'(oBusy), 0);
    chk("rst_oDone", int'(oDone), 0);
    chk("rst_oErr", int'(oErr), 0);
    chk("rst_oNumRCO", int'(oNumRCO), 0);
  endtask

  initial begin
    #1 chk_reset_outs();
    repeat (2) @(posedge CLK);
    #3 Reset = 1'b0;
    chk_en = 1'b1;

    // Reset asserted mid-job must clear everything at once.
    @(posedge CLK); #1;
    iStart = 1'b1; iModo = 2'b00; iCarga = 4'h7; iPasos = 8'd6;
    @(posedge CLK); #1;
    iStart = 1'b0;
    build(2'b00, 4'h7, 6, 1'b0, 0);
    repeat (3) @(posedge CLK);
    #2 chk("pre_rst_oENB", int'(oENB), 1);
    chk_en = 1'b0; Reset = 1'b1;
    #1 chk_reset_outs();
    q.delete(); m_d = '0; m_err = 1'b0; m_nrco = '0;
    @(posedge CLK); #3 Reset = 1'b0; chk_en = 1'b1;

    job(2'b00, 4'h3, 8'd5, 1'b0, 0, 1'b0);
    chk("basic_iQ", int'(iQ), 8);
    chk("basic_nrco", int'(oNumRCO), 0);

    job(2'b01, 4'h1, 8'd3, 1'b0, 0, 1'b0);
    chk("down_iQ", int'(iQ), 'hE);
    chk("down_nrco", int'(oNumRCO), 1);

    job(2'b10, 4'h2, 8'd2, 1'b0, 0, 1'b0);
    chk("m3_iQ", int'(iQ), 'hC);

    job(2'b11, 4'hA, 8'd9, 1'b0, 0, 1'b0);
    chk("ldonly_iQ", int'(iQ), 'hA);
    job(2'b00, 4'h6, 8'd0, 1'b0, 0, 1'b0);
    chk("zero_iQ", int'(iQ), 6);

    job(2'b00, 4'h5, 8'd3, 1'b1, 0, 1'b0);
    chk("tmo_err", int'(oErr), 1);
    repeat (2) @(posedge CLK);
    #1 chk("tmo_err_sticky", int'(oErr), 1);

    // Start and abort together in IDLE: abort wins, no job.
    iStart = 1'b1; iAbort = 1'b1; iModo = 2'b00; iCarga = 4'h9; iPasos = 8'd2;
    @(posedge CLK); #1;
    iStart = 1'b0; iAbort = 1'b0;
    chk("startabort_busy", int'(oBusy), 0);
    repeat (2) @(posedge CLK); #1;

    // Abort on RUN 3 with a busy iStart on RUN 1; this job also clears oErr.
    job(2'b00, 4'hF, 8'd10, 1'b0, 3, 1'b1);
    chk("abort_nrco", int'(oNumRCO), 1);
    chk("abort_iQ", int'(iQ), 2);
    chk("abort_err", int'(oErr), 0);
    repeat (3) @(posedge CLK); #1;

    job(2'b01, 4'h2, 8'd4, 1'b0, 0, 1'b0);
    chk("after_abort_iQ", int'(iQ), 'hE);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
